// File: rtl/spi_input_conditioner.sv
// -----------------------------------------------------------------------------
// spi_input_conditioner
//
// Conditions the raw SPI pad inputs (bit0 = cs, bit1 = sclk, bit2 = mosi) for
// the SPI memory slave. Each channel is brought into the clk domain by a
// two-flop synchronizer and then debounced. The block emits clean levels plus
// one-cycle rising/falling strobes that coincide with the cycle in which the
// conditioned level first shows the new value.
//
// Optional feature macro: SPI_COND_DEBOUNCE_EN
//   defined   - per-channel debounce counters. A change at the synchronizer
//               output must persist for WAIT_TIME+1 consecutive cycles before
//               it commits.
//   undefined - no counters. The synchronizer output is forwarded every edge,
//               and any difference produces a strobe.
//
// Parameters:
//   WIDTH          number of channels
//   COUNTER_WIDTH  width of each debounce counter (debounce build only)
//   WAIT_TIME      extra stable cycles before a change commits (debounce only)
//   RESET_VAL      per-channel reset level (cs idles high)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   noisysignal   in   [WIDTH]  raw asynchronous pad inputs
//   conditioned   out  [WIDTH]  synchronized, debounced levels
//   positiveedge  out  [WIDTH]  one-cycle strobe on conditioned 0->1
//   negativeedge  out  [WIDTH]  one-cycle strobe on conditioned 1->0
// -----------------------------------------------------------------------------
module spi_input_conditioner #(
    parameter int unsigned       WIDTH         = 3,
    parameter int unsigned       COUNTER_WIDTH = 4,
    parameter int unsigned       WAIT_TIME     = 3,
    parameter logic [WIDTH-1:0]  RESET_VAL     = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] noisysignal,
    output logic [WIDTH-1:0] conditioned,
    output logic [WIDTH-1:0] positiveedge,
    output logic [WIDTH-1:0] negativeedge
);

    // The counter must be able to reach WAIT_TIME without wrapping.
    if (WAIT_TIME > (2 ** COUNTER_WIDTH) - 1) begin : g_bad_wait_time
        $error("WAIT_TIME does not fit in COUNTER_WIDTH bits");
    end

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync1;

    // Two-flop synchronizer; only sync1 is used downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0 <= RESET_VAL;
            sync1 <= RESET_VAL;
        end else begin
            sync0 <= noisysignal;
            sync1 <= sync0;
        end
    end

`ifdef SPI_COND_DEBOUNCE_EN

    logic [COUNTER_WIDTH-1:0] cnt [WIDTH];

    // Per channel:
    //   match  : sync1 equals the committed level -> clear count, no strobe
    //   count  : differs, count not yet WAIT_TIME -> increment
    //   commit : differs for WAIT_TIME+1 cycles    -> take new level, strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conditioned  <= RESET_VAL;
            positiveedge <= '0;
            negativeedge <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                positiveedge[i] <= 1'b0;
                negativeedge[i] <= 1'b0;
                if (sync1[i] == conditioned[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != COUNTER_WIDTH'(WAIT_TIME)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    cnt[i]          <= '0;
                    conditioned[i]  <= sync1[i];
                    positiveedge[i] <= sync1[i];
                    negativeedge[i] <= ~sync1[i];
                end
            end
        end
    end

`else

    // No filtering: forward sync1 and strobe on every difference.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conditioned  <= RESET_VAL;
            positiveedge <= '0;
            negativeedge <= '0;
        end else begin
            conditioned  <= sync1;
            positiveedge <= sync1 & ~conditioned;
            negativeedge <= ~sync1 & conditioned;
        end
    end

`endif

endmodule

// File: tb/tb_spi_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_spi_input_conditioner
//
// Self-checking bench for spi_input_conditioner. The reference model works
// from input history: a channel commits once the synchronized input has
// differed from the committed level for REQ consecutive cycles. REQ is
// WAIT_TIME+1 with SPI_COND_DEBOUNCE_EN defined and 1 otherwise. A level
// applied before edge 0 is therefore present at the outputs when edge REQ+2
// arrives.
// -----------------------------------------------------------------------------
module tb_spi_input_conditioner;

    localparam int unsigned      WIDTH         = 3;
    localparam int unsigned      COUNTER_WIDTH = 4;
    localparam int unsigned      WAIT_TIME     = 3;
    localparam logic [WIDTH-1:0] RESET_VAL     = 3'b001;
`ifdef SPI_COND_DEBOUNCE_EN
    localparam int REQ = WAIT_TIME + 1;
`else
    localparam int REQ = 1;
`endif
    localparam int LAT = REQ + 2;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] noisysignal;
    logic [WIDTH-1:0] conditioned;
    logic [WIDTH-1:0] positiveedge;
    logic [WIDTH-1:0] negativeedge;

    int errors = 0;
    int checks = 0;

    spi_input_conditioner #(
        .WIDTH         (WIDTH),
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .WAIT_TIME     (WAIT_TIME),
        .RESET_VAL     (RESET_VAL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .noisysignal  (noisysignal),
        .conditioned  (conditioned),
        .positiveedge (positiveedge),
        .negativeedge (negativeedge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [WIDTH-1:0] m_cond, m_pe, m_ne;
    logic [WIDTH-1:0] hist [2];   // hist[0] = input two edges ago, hist[1] = one edge ago
    int               m_run [WIDTH];

    task automatic model_reset();
        m_cond  = RESET_VAL;
        m_pe    = '0;
        m_ne    = '0;
        hist[0] = RESET_VAL;
        hist[1] = RESET_VAL;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    endtask

    // One rising edge: update the model, then step 1 ns off the edge.
    task automatic tick();
        @(posedge clk);
        m_pe = '0;
        m_ne = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (hist[0][i] !== m_cond[i]) begin
                m_run[i]++;
                if (m_run[i] == REQ) begin
                    m_cond[i] = hist[0][i];
                    m_pe[i]   = hist[0][i];
                    m_ne[i]   = ~hist[0][i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        hist[0] = hist[1];
        hist[1] = noisysignal;
        #1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        noisysignal = 3'b001;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            noisysignal = WIDTH'($urandom);
            checks++;
            if (conditioned !== 3'b001 || positiveedge !== 3'b000 || negativeedge !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold: cond=%b pe=%b ne=%b expected cond=001 pe=000 ne=000",
                         conditioned, positiveedge, negativeedge);
            end
        end
        noisysignal = 3'b001;
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (conditioned !== 3'b001 || positiveedge !== 3'b000 || negativeedge !== 3'b000) begin
                errors++;
                $display("FAIL reset_release_quiet: cond=%b pe=%b ne=%b expected cond=001 pe=000 ne=000",
                         conditioned, positiveedge, negativeedge);
            end
        end
    endtask

    task automatic test_clean_rise();
        noisysignal = 3'b011;
        // Tick e is edge e; what follows it is what edge e+1 sees.
        for (int e = 0; e < LAT + 3; e++) begin
            tick();
            checks++;
            if (conditioned[1] !== ((e + 1) >= LAT) || positiveedge[1] !== ((e + 1) == LAT)
                || negativeedge[1] !== 1'b0) begin
                errors++;
                $display("FAIL clean_rise edge %0d: cond1=%b pe1=%b ne1=%b expected cond1=%b pe1=%b ne1=0",
                         e + 1, conditioned[1], positiveedge[1], negativeedge[1],
                         ((e + 1) >= LAT), ((e + 1) == LAT));
            end
        end
        noisysignal = 3'b001;
        settle(LAT + 2);
    endtask

    task automatic test_glitch();
        int pe_at, ne_at;
`ifdef SPI_COND_DEBOUNCE_EN
        // A WAIT_TIME-cycle pulse must vanish.
        noisysignal = 3'b101;
        settle(WAIT_TIME);
        noisysignal = 3'b001;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (conditioned !== 3'b001 || positiveedge !== 3'b000 || negativeedge !== 3'b000) begin
                errors++;
                $display("FAIL glitch_short: cond=%b pe=%b ne=%b expected cond=001 pe=000 ne=000",
                         conditioned, positiveedge, negativeedge);
            end
        end
`else
        // Without filtering a single-cycle pulse yields rise then fall strobes.
        noisysignal = 3'b101;
        tick();
        noisysignal = 3'b001;
        pe_at = -1;
        ne_at = -1;
        for (int k = 1; k < 10; k++) begin
            tick();
            if (positiveedge[2] === 1'b1 && pe_at < 0) pe_at = k;
            if (negativeedge[2] === 1'b1 && ne_at < 0) ne_at = k;
        end
        checks++;
        if (pe_at != LAT - 1 || ne_at != LAT) begin
            errors++;
            $display("FAIL pulse_passthrough: pe at %0d ne at %0d expected %0d and %0d",
                     pe_at, ne_at, LAT - 1, LAT);
        end
`endif
        // A (WAIT_TIME+1)-cycle pulse passes and keeps its width.
        noisysignal = 3'b101;
        pe_at = -1;
        ne_at = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == WAIT_TIME) noisysignal = 3'b001;
            if (positiveedge[2] === 1'b1 && pe_at < 0) pe_at = k;
            if (negativeedge[2] === 1'b1 && ne_at < 0) ne_at = k;
        end
        checks++;
        if (pe_at != LAT - 1 || ne_at != LAT - 1 + WAIT_TIME + 1) begin
            errors++;
            $display("FAIL glitch_pass: pe at %0d ne at %0d expected %0d and %0d",
                     pe_at, ne_at, LAT - 1, LAT + WAIT_TIME);
        end
    endtask

    task automatic test_simultaneous();
        noisysignal = 3'b010;
        for (int e = 0; e < LAT + 2; e++) begin
            tick();
            checks++;
            if (e + 1 == LAT) begin
                if (positiveedge !== 3'b010 || negativeedge !== 3'b001 || conditioned !== 3'b010) begin
                    errors++;
                    $display("FAIL simultaneous: cond=%b pe=%b ne=%b expected cond=010 pe=010 ne=001",
                             conditioned, positiveedge, negativeedge);
                end
            end else if (positiveedge !== 3'b000 || negativeedge !== 3'b000) begin
                errors++;
                $display("FAIL simultaneous_quiet edge %0d: pe=%b ne=%b expected pe=000 ne=000",
                         e + 1, positiveedge, negativeedge);
            end
        end
        noisysignal = 3'b001;
        settle(LAT + 2);
    endtask

    task automatic test_reset_mid();
        int pe_at;
        noisysignal = 3'b011;
        settle(3);                 // edges 0..2: ch1 now part-way through its count
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (conditioned !== 3'b001 || positiveedge !== 3'b000 || negativeedge !== 3'b000) begin
            errors++;
            $display("FAIL reset_async: cond=%b pe=%b ne=%b expected cond=001 pe=000 ne=000",
                     conditioned, positiveedge, negativeedge);
        end
        model_reset();
        #12;
        reset_n = 1'b1;
        pe_at = -1;
        for (int e = 0; e < LAT + 4; e++) begin
            tick();
            if (positiveedge[1] === 1'b1 && pe_at < 0) pe_at = e;
        end
        checks++;
        if (pe_at != LAT - 1 || conditioned !== 3'b011) begin
            errors++;
            $display("FAIL reset_mid_recommit: pe at %0d cond=%b expected %0d cond=011",
                     pe_at, conditioned, LAT - 1);
        end
        noisysignal = 3'b001;
        settle(LAT + 2);
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int k = 0; k < 600; k++) begin
            if (hold == 0) begin
                noisysignal = WIDTH'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            tick();
            checks++;
            if (conditioned !== m_cond || positiveedge !== m_pe || negativeedge !== m_ne
                || (positiveedge & negativeedge) !== 3'b000) begin
                errors++;
                $display("FAIL random cycle %0d: cond=%b pe=%b ne=%b expected cond=%b pe=%b ne=%b",
                         k, conditioned, positiveedge, negativeedge, m_cond, m_pe, m_ne);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
